// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a start/busy/done handshake; single-cycle ops finish in one edge.
// Iterative mul/divu (shift-add, restoring) are compiled only when SEQ_ALU_MULDIV_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  // S_IDLE: wait for start | S_RUN: one mul/div step per cycle | S_DONE: done pulse, accepts start
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef SEQ_ALU_MULDIV_EN
    , S_RUN = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum, diff, sc_res;
  logic             sc_ovf;

  assign sum  = in1 + in2;
  assign diff = in1 - in2;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (funct)
      3'b000: begin
        sc_res = sum;
        sc_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      3'b001: begin
        sc_res = diff;
        sc_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      3'b010:  sc_res = in1 & in2;
      3'b011:  sc_res = in1 | in2;
      3'b100:  sc_res = WIDTH'($signed(in1) < $signed(in2));
      3'b101:  sc_res = WIDTH'(in1 < in2);
      default: sc_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  // acc: product high half / partial remainder; sh: multiplier / dividend-then-quotient
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opb_q, opb_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_t, div_t;
  logic             div_ge;
  logic [WIDTH-1:0] div_r, step_acc, step_sh;

  always_comb begin
    mul_t  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
    div_t  = {acc_q, sh_q[WIDTH-1]};
    div_ge = (div_t >= {1'b0, opb_q});
    div_r  = div_ge ? (div_t[WIDTH-1:0] - opb_q) : div_t[WIDTH-1:0];
    if (div_q) begin
      step_acc = div_r;
      step_sh  = {sh_q[WIDTH-2:0], div_ge};
    end else begin
      step_acc = mul_t[WIDTH:1];
      step_sh  = {mul_t[0], sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sh_q  <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opb_q <= opb_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
`ifdef SEQ_ALU_MULDIV_EN
    acc_d = acc_q;
    sh_d  = sh_q;
    opb_d = opb_q;
    div_d = div_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (funct[2:1] == 2'b11) begin
            state_d = S_RUN;
            acc_d   = '0;
            sh_d    = funct[0] ? in1 : in2;
            opb_d   = funct[0] ? in2 : in1;
            div_d   = funct[0];
            cnt_d   = CW'(WIDTH);
          end else
`endif
          begin
            state_d     = S_DONE;
            result_d    = sc_res;
            result_hi_d = '0;
            zero_d      = (sc_res == '0);
            ovf_d       = sc_ovf;
          end
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      S_RUN: begin
        acc_d = step_acc;
        sh_d  = step_sh;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          result_d    = step_sh;
          result_hi_d = step_acc;
          zero_d      = (step_sh == '0);
          ovf_d       = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign done      = (state_q == S_DONE);

endmodule
